spi_gyro_responder: RTL and testbench
=====================================

Name: spi_gyro_responder

Overview:
SPI slave (mode 3: CPOL=1, CPHA=1, MSB first) that emulates the gyro's register interface. It lets the gyro master be exercised in simulation and on-board loopback without the physical sensor. It runs on the system clock, oversamples sclk/cs/mosi and drives miso. It serves WHO_AM_I, CTRL_REG1..5 and OUT_X_L..OUT_Z_H from sample inputs, with single and multiple (auto-increment) read/write.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchronisers on sclk, cs and mosi.
WHO_AM_I_VAL, 8'hD3, value returned at address 0x0F.
CTRL1_RST, 8'h07, reset value of CTRL_REG1 (0x20). CTRL_REG2..5 reset to 8'h00.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
sclk  in  1  SPI clock from master, idle high
cs  in  1  chip select, active low
mosi  in  1  master-out data
miso  out  1  slave-out data
sample_x  in  16  current X rate, two's complement
sample_y  in  16  current Y rate
sample_z  in  16  current Z rate
ctrl1  out  8  current CTRL_REG1 contents
wr_strobe  out  1  one-cycle pulse per accepted register write
wr_addr  out  6  address of that write
wr_data  out  8  data of that write
busy  out  1  high while a transaction is active (cs low)

Behaviour:
- Reset values: miso=0, wr_strobe=0, wr_addr=0, wr_data=0, busy=0, ctrl1=CTRL1_RST, CTRL_REG2..5=0, state=IDLE. Synchroniser flops also reset, to sclk=1, cs=1, mosi=0.
- All SPI pins pass through SYNC_STAGES flops. Edges are detected on the synchronised values.
- Master timing requirement: each sclk half-period is at least SYNC_STAGES+3 clk cycles.
- States:
  - IDLE: wait for a cs falling edge.
  - CMD: shift in the first byte.
  - DATA: shift in or out the following bytes.
  - DRAIN: entered when reset is released while cs is low; wait for cs high, then go to IDLE.
- At the cs falling edge: latch {sample_z, sample_y, sample_x} into a 48-bit snapshot, set busy=1, clear the bit counter, go to CMD. Reads return the snapshot, so multi-byte reads are coherent.
- On each synchronised sclk rising edge, shift mosi in. On each synchronised sclk falling edge, shift miso out. miso updates within SYNC_STAGES+1 clk of the edge.
- CMD byte format: bit7 R(1)/W(0), bit6 MS (auto-increment), bits5:0 address. miso=0 throughout CMD.
- Read path: when the 8th CMD bit is sampled, load the shift-out register with reg[addr]. Its MSB goes to miso on the next falling edge.
  - After each data byte: if MS=1, addr increments and wraps 0x3F to 0x00; if MS=0, addr is unchanged.
  - The next value is loaded at that byte's 8th rising edge.
- Read map:
  - 0x0F returns WHO_AM_I_VAL.
  - 0x20..0x24 return CTRL_REG1..5.
  - 0x28..0x2D return X_L, X_H, Y_L, Y_H, Z_L, Z_H from the snapshot.
  - Every other address returns 0x00.
- Write path: each completed data byte (8th rising edge) goes to the current addr, then addr advances per MS.
  - Addresses 0x20..0x24 update the register and pulse wr_strobe for one clk, with wr_addr/wr_data valid in the same cycle. ctrl1 reflects the new value on the following cycle.
  - Writes to any other address are silently dropped: no strobe, no state change.
- Inside DATA: miso shows the MSB of the loaded read byte. For writes, miso=0.
- cs rising edge at any point: discard any partial byte, no write, busy=0, miso=0, go to IDLE. A partial CMD byte likewise has no effect.
- cs rising and sclk rising in the same clk: cs takes priority, so the bit is ignored.
- Synchronous reset mid-transaction aborts immediately. If cs is still low afterwards, the block sits in DRAIN and no bytes are decoded until cs has gone high.
- Snapshot is not updated while cs stays low; sample inputs may change freely.

Decomposition:
- Package gyro_pkg holds:
  - Register address constants: WHO_AM_I=0x0F, CTRL_REG1..5=0x20..0x24, OUT_X_L=0x28 .. OUT_Z_H=0x2D.
  - Command bit positions: RW=7, MS=6.
  - The state enum.
- One natural sub-module: spi_slave_phy. It holds the synchronisers, edge detection, 8-bit shift-in/out and a byte_done strobe. It has no knowledge of the register map.
- spi_gyro_responder adds the command decode, address counter, register bank and snapshot.

Test Plan:
1. Reset, then read 0x8F followed by one dummy byte -> second MISO byte 0xD3, busy high only while cs is low, no wr_strobe.
2. Setup sequence written as three transactions: {0x20,0x0F}, {0x24,0x10}, {0x21,0x00} -> three wr_strobe pulses with (0x20,0x0F), (0x24,0x10), (0x21,0x00); ctrl1=0x0F; reading 0xA4 returns 0x10.
3. sample_x=0x1234, sample_y=0xABCD, sample_z=0x8001, then the multi-read 0xE8 plus 6 dummy bytes -> MISO bytes 34 12 CD AB 01 80. Changing the samples mid-transaction does not alter the bytes.
4. Write 0x20 (MS=0) with data bytes 0x11, 0x22 -> two strobes, both at addr 0x20; final ctrl1=0x22. Write to 0x0F with 0x55 -> no strobe, WHO_AM_I still reads 0xD3.
5. Raise cs after 4 bits of a data byte in a write to 0x20 -> no strobe, ctrl1 unchanged. The next full transaction decodes normally.
6. Assert rst in the middle of a read with cs held low, then release it and continue clocking -> miso=0, no decode until cs goes high. The following read of 0x8F returns 0xD3 and ctrl1=0x07.

Source files
------------

// File: rtl/gyro_pkg.sv
// Shared definitions for the emulated gyro register interface: register map,
// command-byte layout and responder state encoding.
package gyro_pkg;

  localparam logic [5:0] WHO_AM_I  = 6'h0F;
  localparam logic [5:0] CTRL_REG1 = 6'h20;
  localparam logic [5:0] CTRL_REG2 = 6'h21;
  localparam logic [5:0] CTRL_REG3 = 6'h22;
  localparam logic [5:0] CTRL_REG4 = 6'h23;
  localparam logic [5:0] CTRL_REG5 = 6'h24;
  localparam logic [5:0] OUT_X_L   = 6'h28;
  localparam logic [5:0] OUT_X_H   = 6'h29;
  localparam logic [5:0] OUT_Y_L   = 6'h2A;
  localparam logic [5:0] OUT_Y_H   = 6'h2B;
  localparam logic [5:0] OUT_Z_L   = 6'h2C;
  localparam logic [5:0] OUT_Z_H   = 6'h2D;

  localparam int CMD_RW = 7;
  localparam int CMD_MS = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_DRAIN
  } gyro_state_e;

  typedef struct packed {
    logic       rw;
    logic       ms;
    logic [5:0] addr;
  } gyro_cmd_t;

endpackage

// File: rtl/spi_slave_phy.sv
// Mode-3 SPI slave bit layer: pin synchronisers, edge detection and byte
// shift-in/shift-out. Knows nothing about the register map.
module spi_slave_phy #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs,
  input  logic       mosi,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] load_data,
  output logic       miso,
  output logic       cs_low,
  output logic       cs_fall,
  output logic       cs_rise,
  output logic       byte_done,
  output logic [7:0] rx_byte
);

  // One extra stage past the synchroniser holds the previous value for edge detection.
  logic [SYNC_STAGES:0]   sclk_sh, cs_sh;
  logic [SYNC_STAGES-1:0] mosi_sh;
  logic       sclk_rise, sclk_fall, mosi_s, shift_ok;
  logic [2:0] bit_cnt;
  logic [6:0] rx_sr;
  logic [7:0] tx_sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sh <= '1;
      cs_sh   <= '1;
      mosi_sh <= '0;
    end else begin
      sclk_sh <= {sclk_sh[SYNC_STAGES-1:0], sclk};
      cs_sh   <= {cs_sh[SYNC_STAGES-1:0], cs};
      mosi_sh <= (mosi_sh << 1) | SYNC_STAGES'(mosi);
    end
  end

  assign mosi_s    = mosi_sh[SYNC_STAGES-1];
  assign sclk_rise = sclk_sh[SYNC_STAGES-1] & ~sclk_sh[SYNC_STAGES];
  assign sclk_fall = ~sclk_sh[SYNC_STAGES-1] & sclk_sh[SYNC_STAGES];
  assign cs_low    = ~cs_sh[SYNC_STAGES-1];
  assign cs_fall   = cs_low & cs_sh[SYNC_STAGES];
  assign cs_rise   = ~cs_low & ~cs_sh[SYNC_STAGES];

  // cs deassertion wins over a coincident sclk edge.
  assign shift_ok  = en & sclk_rise & ~cs_rise;
  assign byte_done = shift_ok & (bit_cnt == 3'd7);
  assign rx_byte   = {rx_sr, mosi_s};

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      rx_sr   <= '0;
      tx_sr   <= '0;
      miso    <= 1'b0;
    end else if (!en || cs_rise) begin
      bit_cnt <= '0;
      rx_sr   <= '0;
      tx_sr   <= '0;
      miso    <= 1'b0;
    end else begin
      if (shift_ok) begin
        bit_cnt <= bit_cnt + 3'd1;
        rx_sr   <= rx_byte[6:0];
      end
      if (load) begin
        tx_sr <= load_data;
      end else if (sclk_fall) begin
        miso  <= tx_sr[7];
        tx_sr <= {tx_sr[6:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/spi_gyro_responder.sv
// Gyro register-interface emulator: command decode, address counter,
// CTRL register bank and coherent sample snapshot on top of the SPI PHY.
module spi_gyro_responder
  import gyro_pkg::*;
#(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [7:0] WHO_AM_I_VAL = 8'hD3,
  parameter logic [7:0] CTRL1_RST    = 8'h07
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        cs,
  input  logic        mosi,
  output logic        miso,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  output logic [7:0]  ctrl1,
  output logic        wr_strobe,
  output logic [5:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy
);

  gyro_state_e     state, state_nxt;
  gyro_cmd_t       rx_cmd;
  logic            cmd_rw, cmd_ms;
  logic [5:0]      addr, addr_nxt;
  logic [4:0][7:0] ctrl_q;
  logic [47:0]     snap;
  logic [SYNC_STAGES:0] grd_pipe;
  logic            guard, en, load, wr_hit;
  logic            cs_low, cs_fall, cs_rise, byte_done;
  logic [7:0]      load_data, rx_byte;
  logic [2:0]      ctrl_idx;

  spi_slave_phy #(.SYNC_STAGES(SYNC_STAGES)) u_phy (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .cs        (cs),
    .mosi      (mosi),
    .en        (en),
    .load      (load),
    .load_data (load_data),
    .miso      (miso),
    .cs_low    (cs_low),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .byte_done (byte_done),
    .rx_byte   (rx_byte)
  );

  function automatic logic [7:0] rd_val(input logic [5:0] a);
    logic [7:0] v;
    v = 8'h00;
    if (a == WHO_AM_I)                       v = WHO_AM_I_VAL;
    else if (a inside {[CTRL_REG1:CTRL_REG5]}) v = ctrl_q[a[2:0]];
    else if (a inside {[OUT_X_L:OUT_Z_H]})     v = snap[{a[2:0], 3'b000} +: 8];
    return v;
  endfunction

  assign rx_cmd   = gyro_cmd_t'(rx_byte);
  assign en       = (state == ST_CMD) || (state == ST_DATA);
  assign addr_nxt = cmd_ms ? addr + 6'd1 : addr;
  assign ctrl_idx = 3'(addr - CTRL_REG1);
  assign wr_hit   = (state == ST_DATA) && byte_done && !cmd_rw &&
                    (addr inside {[CTRL_REG1:CTRL_REG5]});
  assign ctrl1    = ctrl_q[0];

  // The synchronisers reset to cs=1, so a cs already low at reset release looks
  // like a falling edge for the first few cycles; those edges lead to DRAIN.
  assign guard = grd_pipe[SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_data = 8'h00;
    case (state)
      ST_IDLE:  if (cs_fall) state_nxt = guard ? ST_DRAIN : ST_CMD;
      ST_CMD: begin
        if (cs_rise) state_nxt = ST_IDLE;
        else if (byte_done) begin
          state_nxt = ST_DATA;
          load      = 1'b1;
          load_data = rx_cmd.rw ? rd_val(rx_cmd.addr) : 8'h00;
        end
      end
      ST_DATA: begin
        if (cs_rise) state_nxt = ST_IDLE;
        else if (byte_done) begin
          load      = 1'b1;
          load_data = cmd_rw ? rd_val(addr_nxt) : 8'h00;
        end
      end
      ST_DRAIN: if (!cs_low) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grd_pipe  <= '1;
      cmd_rw    <= 1'b0;
      cmd_ms    <= 1'b0;
      addr      <= '0;
      ctrl_q    <= '0;
      ctrl_q[0] <= CTRL1_RST;
      snap      <= '0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      grd_pipe  <= grd_pipe << 1;
      busy      <= (state_nxt == ST_CMD) || (state_nxt == ST_DATA);
      wr_strobe <= wr_hit;
      if (wr_hit) begin
        wr_addr          <= addr;
        wr_data          <= rx_byte;
        ctrl_q[ctrl_idx] <= rx_byte;
      end
      if (state == ST_IDLE && state_nxt == ST_CMD)
        snap <= {sample_z, sample_y, sample_x};
      if (state == ST_CMD && byte_done && !cs_rise) begin
        cmd_rw <= rx_cmd.rw;
        cmd_ms <= rx_cmd.ms;
        addr   <= rx_cmd.addr;
      end else if (state == ST_DATA && byte_done) begin
        addr <= addr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_spi_gyro_responder.sv
// Directed bench for spi_gyro_responder: an SPI mode-3 master task drives
// transactions while monitors check MISO bytes and write strobes against queues.
module tb_spi_gyro_responder;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b1;
  logic        cs = 1'b1;
  logic        mosi = 1'b0;
  logic [15:0] sample_x = '0, sample_y = '0, sample_z = '0;
  logic        miso, wr_strobe, busy;
  logic [7:0]  ctrl1, wr_data;
  logic [5:0]  wr_addr;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0]  rd_q[$];
  logic [13:0] wr_q[$];
  logic [7:0]  tx_buf[8];

  spi_gyro_responder #(
    .SYNC_STAGES(2), .WHO_AM_I_VAL(8'hD3), .CTRL1_RST(8'h07)
  ) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
    .sample_x(sample_x), .sample_y(sample_y), .sample_z(sample_z),
    .ctrl1(ctrl1), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic exp_rd(input logic [7:0] v);
    rd_q.push_back(v);
  endtask

  task automatic exp_wr(input logic [5:0] a, input logic [7:0] d);
    wr_q.push_back({a, d});
  endtask

  // Assemble MISO bytes as the master samples them (sclk rising) and score them.
  initial begin
    int bc;
    logic [7:0] sh;
    bc = 0;
    sh = '0;
    forever begin
      @(posedge sclk or posedge cs);
      if (cs) bc = 0;
      else begin
        sh = {sh[6:0], miso};
        bc++;
        if (bc == 8) begin
          bc = 0;
          if (rd_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL miso_unexpected: got 0x%0h, expected no byte", sh);
          end else chk("miso_byte", sh, rd_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [13:0] e;
    forever begin
      @(negedge clk);
      if (!rst && wr_strobe) begin
        if (wr_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h, expected no strobe", wr_addr, wr_data);
        end else begin
          e = wr_q.pop_front();
          chk("wr_addr", wr_addr, e[13:8]);
          chk("wr_data", wr_data, e[7:0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  // Mode 3: mosi changes on falling sclk, sampled on rising. Optional partial
  // trailing byte, and optional reset pulse after a given byte with cs held low.
  task automatic xfer(input int nbytes, input int part_bits, input int rst_after);
    int total;
    total = nbytes * 8 + part_bits;
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < total; k++) begin
      sclk = 1'b0;
      mosi = tx_buf[k / 8][7 - (k % 8)];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      if ((k % 8) == 7 && (k + 1) / 8 == rst_after) begin
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("miso_after_rst", miso, 0);
        chk("ctrl1_after_rst", ctrl1, 8'h07);
      end
    end
    cs = 1'b1;
    mosi = 1'b0;
    repeat (3 * HALF) @(negedge clk);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_miso", miso, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_strobe", wr_strobe, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_ctrl1", ctrl1, 8'h07);

    // 1: WHO_AM_I read, busy only while cs low
    tx_buf[0] = 8'h8F; tx_buf[1] = 8'h00;
    exp_rd(8'h00); exp_rd(8'hD3);
    fork
      xfer(2, 0, 0);
      begin
        repeat (HALF * 4) @(negedge clk);
        chk("busy_active", busy, 1);
      end
    join
    chk("busy_idle", busy, 0);

    // 2: setup writes, then read CTRL_REG5
    tx_buf[0] = 8'h20; tx_buf[1] = 8'h0F; exp_rd(8'h00); exp_rd(8'h00); exp_wr(6'h20, 8'h0F);
    xfer(2, 0, 0);
    tx_buf[0] = 8'h24; tx_buf[1] = 8'h10; exp_rd(8'h00); exp_rd(8'h00); exp_wr(6'h24, 8'h10);
    xfer(2, 0, 0);
    tx_buf[0] = 8'h21; tx_buf[1] = 8'h00; exp_rd(8'h00); exp_rd(8'h00); exp_wr(6'h21, 8'h00);
    xfer(2, 0, 0);
    chk("ctrl1_setup", ctrl1, 8'h0F);
    tx_buf[0] = 8'hA4; tx_buf[1] = 8'h00; exp_rd(8'h00); exp_rd(8'h10);
    xfer(2, 0, 0);

    // 3: coherent multi-byte sample read, samples change mid-transaction
    sample_x = 16'h1234; sample_y = 16'hABCD; sample_z = 16'h8001;
    tx_buf[0] = 8'hE8;
    for (int i = 1; i < 7; i++) tx_buf[i] = 8'h00;
    exp_rd(8'h00);
    exp_rd(8'h34); exp_rd(8'h12); exp_rd(8'hCD); exp_rd(8'hAB); exp_rd(8'h01); exp_rd(8'h80);
    fork
      xfer(7, 0, 0);
      begin
        repeat (40) @(negedge clk);
        sample_x = 16'hFFFF; sample_y = 16'h0000; sample_z = 16'h7777;
      end
    join

    // 4: non-incrementing double write; write to read-only address dropped
    tx_buf[0] = 8'h20; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22;
    exp_rd(8'h00); exp_rd(8'h00); exp_rd(8'h00);
    exp_wr(6'h20, 8'h11); exp_wr(6'h20, 8'h22);
    xfer(3, 0, 0);
    chk("ctrl1_ms0", ctrl1, 8'h22);
    tx_buf[0] = 8'h0F; tx_buf[1] = 8'h55; exp_rd(8'h00); exp_rd(8'h00);
    xfer(2, 0, 0);
    tx_buf[0] = 8'h8F; tx_buf[1] = 8'h00; exp_rd(8'h00); exp_rd(8'hD3);
    xfer(2, 0, 0);

    // 5: cs raised after half a data byte
    tx_buf[0] = 8'h20; tx_buf[1] = 8'hAA; exp_rd(8'h00);
    xfer(1, 4, 0);
    chk("ctrl1_partial", ctrl1, 8'h22);
    tx_buf[0] = 8'h20; tx_buf[1] = 8'h5A; exp_rd(8'h00); exp_rd(8'h00); exp_wr(6'h20, 8'h5A);
    xfer(2, 0, 0);
    chk("ctrl1_after_partial", ctrl1, 8'h5A);

    // 6: reset mid-read with cs low; trailing bytes would be a write if decoded
    tx_buf[0] = 8'h8F; tx_buf[1] = 8'h00; tx_buf[2] = 8'h20; tx_buf[3] = 8'h99;
    exp_rd(8'h00); exp_rd(8'hD3); exp_rd(8'h00); exp_rd(8'h00);
    xfer(4, 0, 2);
    tx_buf[0] = 8'h8F; tx_buf[1] = 8'h00; exp_rd(8'h00); exp_rd(8'hD3);
    xfer(2, 0, 0);
    chk("ctrl1_final", ctrl1, 8'h07);

    repeat (10) @(negedge clk);
    chk("rd_q_drained", rd_q.size(), 0);
    chk("wr_q_drained", wr_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
